// File: rtl/writeback_regfile_pkg.sv
// ---------------------------------------------------------------------------
// writeback_regfile_pkg
// Shared constants for the 8-bit pipeline's writeback stage and register
// file. The pipeline registers and decode import this same package, so the
// widths and select encodings stay in one place.
//   DATA_W_DEF / ADDR_W_DEF / CNT_W_DEF : default datapath, address and
//                                         commit-counter widths
//   ZERO_REG                            : index of the hard-wired zero register
//   WB_SRC_ALU / WB_SRC_MEM             : writeback source select encodings
// ---------------------------------------------------------------------------
package writeback_regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 16;

  localparam int unsigned ZERO_REG = 0;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

endpackage

// File: rtl/gpr_array.sv
// ---------------------------------------------------------------------------
// gpr_array
// General-purpose register storage: one synchronous write port, two
// asynchronous read ports. Register 0 is hard-wired to zero: writes to it are
// dropped and reads of it return zero.
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   we_i, waddr_i, wdata_i: write port (commits on rising edge)
//   raddr_a_i / rdata_a_o : read port A
//   raddr_b_i / rdata_b_o : read port B
// ---------------------------------------------------------------------------
module gpr_array
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];

  // NOTE: this array is small and must read as zero straight out of reset,
  // so every entry is cleared by the async reset rather than left as RAM.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != R0)) begin
      // NOTE: state is updated with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == R0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == R0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
// Writeback stage plus register file. Selects ALU result or memory data as
// the writeback value, commits it into the register file, serves two
// combinational read ports with same-cycle write-through bypass, and keeps a
// saturating count of committed writes for bring-up.
//   clk_i, rst_n_i             : clock, asynchronous active-low reset
//   regwrite_i                 : writeback enable this cycle
//   write_data_control_i       : source select (1 = q_i, 0 = alu_result_i)
//   alu_result_i, q_i          : candidate writeback values
//   write_addr_i               : destination register
//   rd_addr_a_i / rd_data_a_o  : read port A (rs)
//   rd_addr_b_i / rd_data_b_o  : read port B (rt)
//   wb_data_o                  : selected writeback value, for forwarding
//   wb_valid_o                 : a real (non-r0) write is happening
//   commit_count_o             : saturating committed-write counter
// ---------------------------------------------------------------------------
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              regwrite_i,
  input  logic              write_data_control_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_valid_o,
  output logic [CNT_W-1:0]  commit_count_o
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] stor_a;
  logic [DATA_W-1:0] stor_b;
  logic              bypass_a;
  logic              bypass_b;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  // Writeback source select.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path
    // leaves it unassigned and infers a latch.
    wb_data = alu_result_i;
    case (write_data_control_i)
      WB_SRC_MEM: wb_data = q_i;
      WB_SRC_ALU: wb_data = alu_result_i;
      default:    wb_data = alu_result_i;
    endcase
  end

  assign wb_data_o  = wb_data;
  assign wb_valid_o = regwrite_i && (write_addr_i != R0);

  gpr_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_gpr_array (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .we_i      (regwrite_i),
    .waddr_i   (write_addr_i),
    .wdata_i   (wb_data),
    .raddr_a_i (rd_addr_a_i),
    .raddr_b_i (rd_addr_b_i),
    .rdata_a_o (stor_a),
    .rdata_b_o (stor_b)
  );

  // wb_valid_o already excludes r0, so an address match implies a nonzero
  // read address. Bypass is suppressed in reset so the ports read zero.
  assign bypass_a = rst_n_i && wb_valid_o && (write_addr_i == rd_addr_a_i);
  assign bypass_b = rst_n_i && wb_valid_o && (write_addr_i == rd_addr_b_i);

  assign rd_data_a_o = bypass_a ? wb_data : stor_a;
  assign rd_data_b_o = bypass_b ? wb_data : stor_b;

  // Saturating commit counter: holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (wb_valid_o && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign commit_count_o = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
// Self-checking bench for writeback_regfile. A behavioural model (plain array
// of register values plus an integer commit count) tracks what the register
// file must hold; a compare process checks every output against it on each
// falling edge. Directed sequences add literal expectations for reset,
// source select, bypass, r0, async reset and counter saturation.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;

  localparam int DW     = 8;
  localparam int AW     = 3;
  localparam int CW     = 16;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk_i;
  logic          rst_n_i;
  logic          regwrite_i;
  logic          write_data_control_i;
  logic [DW-1:0] alu_result_i;
  logic [DW-1:0] q_i;
  logic [AW-1:0] write_addr_i;
  logic [AW-1:0] rd_addr_a_i;
  logic [AW-1:0] rd_addr_b_i;
  logic [DW-1:0] rd_data_a_o;
  logic [DW-1:0] rd_data_b_o;
  logic [DW-1:0] wb_data_o;
  logic          wb_valid_o;
  logic [CW-1:0] commit_count_o;

  writeback_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .regwrite_i           (regwrite_i),
    .write_data_control_i (write_data_control_i),
    .alu_result_i         (alu_result_i),
    .q_i                  (q_i),
    .write_addr_i         (write_addr_i),
    .rd_addr_a_i          (rd_addr_a_i),
    .rd_addr_b_i          (rd_addr_b_i),
    .rd_data_a_o          (rd_data_a_o),
    .rd_data_b_o          (rd_data_b_o),
    .wb_data_o            (wb_data_o),
    .wb_valid_o           (wb_valid_o),
    .commit_count_o       (commit_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int model_regs [8];
  int model_count;

  function automatic int exp_wb();
    return write_data_control_i ? int'(q_i) : int'(alu_result_i);
  endfunction

  function automatic int exp_rd(input int a);
    if (!rst_n_i) return 0;
    if (a == 0) return 0;
    if (regwrite_i && (int'(write_addr_i) == a)) return exp_wb();
    return model_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_count = 0;
  endtask

  initial model_clear();

  always @(negedge rst_n_i) model_clear();

  always @(posedge clk_i) begin
    if (rst_n_i && regwrite_i && (write_addr_i != 0)) begin
      model_regs[write_addr_i] = exp_wb();
      if (model_count < CNTMAX) model_count = model_count + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("wb_data",  32'(wb_data_o),      32'(exp_wb()));
      check("wb_valid", 32'(wb_valid_o),     32'(regwrite_i && (write_addr_i != 0)));
      check("rd_a",     32'(rd_data_a_o),    32'(exp_rd(int'(rd_addr_a_i))));
      check("rd_b",     32'(rd_data_b_o),    32'(exp_rd(int'(rd_addr_b_i))));
      check("count",    32'(commit_count_o), 32'(model_count));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic rw, input logic src, input logic [DW-1:0] alu,
                       input logic [DW-1:0] q, input logic [AW-1:0] wa,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    regwrite_i           = rw;
    write_data_control_i = src;
    alu_result_i         = alu;
    q_i                  = q;
    write_addr_i         = wa;
    rd_addr_a_i          = ra;
    rd_addr_b_i          = rb;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    drive(1'b1, 1'b0, 8'h5A, 8'h00, 3'd3, 3'd3, 3'd3);
    #1;
    cmp_en = 1'b1;

    // Reset holds: no write, count 0, reads 0 even with a matching write.
    repeat (3) step();
    check("rst_count", 32'(commit_count_o), 32'h0);
    check("rst_rd_a",  32'(rd_data_a_o),    32'h0);
    check("rst_wbdata", 32'(wb_data_o),     32'h5A);
    drive(1'b0, 1'b0, 8'h5A, 8'h00, 3'd3, 3'd0, 3'd0);
    rst_n_i = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a_i = AW'(i);
      rd_addr_b_i = AW'(7 - i);
      #1;
      check("post_rst_a", 32'(rd_data_a_o), 32'h0);
      check("post_rst_b", 32'(rd_data_b_o), 32'h0);
    end
    step();

    // Source select.
    drive(1'b1, 1'b0, 8'h11, 8'hEE, 3'd2, 3'd0, 3'd0);
    step();
    drive(1'b1, 1'b1, 8'h11, 8'hEE, 3'd5, 3'd0, 3'd0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd2, 3'd5);
    #1;
    check("src_alu_r2", 32'(rd_data_a_o),    32'h11);
    check("src_mem_r5", 32'(rd_data_b_o),    32'hEE);
    check("src_count",  32'(commit_count_o), 32'd2);

    // Bypass: r4 = 0x20, then a same-cycle write of 0x77.
    step();
    drive(1'b1, 1'b0, 8'h20, 8'h00, 3'd4, 3'd0, 3'd0);
    step();
    drive(1'b1, 1'b0, 8'h77, 8'h00, 3'd4, 3'd4, 3'd4);
    #1;
    check("byp_a", 32'(rd_data_a_o), 32'h77);
    check("byp_b", 32'(rd_data_b_o), 32'h77);
    regwrite_i = 1'b0;
    #1;
    check("nobyp_a", 32'(rd_data_a_o), 32'h20);
    check("nobyp_b", 32'(rd_data_b_o), 32'h20);
    step();

    // r0: write discarded, never bypassed, not counted.
    drive(1'b1, 1'b0, 8'hFF, 8'hFF, 3'd0, 3'd0, 3'd4);
    #1;
    check("r0_rd_a",    32'(rd_data_a_o), 32'h0);
    check("r0_wbvalid", 32'(wb_valid_o),  32'h0);
    step();
    regwrite_i = 1'b0;
    #1;
    check("r0_after",  32'(rd_data_a_o),    32'h0);
    check("r0_count",  32'(commit_count_o), 32'd3);
    check("r4_intact", 32'(rd_data_b_o),    32'h20);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      step();
    end

    // Async reset mid-run: known writes, then reset between edges.
    drive(1'b1, 1'b0, 8'hA1, 8'h00, 3'd1, 3'd0, 3'd0);
    step();
    drive(1'b1, 1'b1, 8'h00, 8'hB6, 3'd6, 3'd0, 3'd0);
    step();
    drive(1'b1, 1'b0, 8'hC7, 8'h00, 3'd7, 3'd1, 3'd6);
    #1;
    check("pre_rst_r1", 32'(rd_data_a_o), 32'hA1);
    check("pre_rst_r6", 32'(rd_data_b_o), 32'hB6);
    rst_n_i = 1'b0;
    #1;
    check("arst_r1",    32'(rd_data_a_o),    32'h0);
    check("arst_r6",    32'(rd_data_b_o),    32'h0);
    check("arst_count", 32'(commit_count_o), 32'h0);
    rd_addr_a_i = 3'd7;
    #1;
    check("arst_r7",    32'(rd_data_a_o),    32'h0);
    step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd7, 3'd7);
    rst_n_i = 1'b1;
    #1;
    check("arst_r7_lost", 32'(rd_data_a_o), 32'h0);
    step();

    // Saturation: 65535 commits reach 0xFFFF, further commits hold it.
    for (int n = 0; n < CNTMAX; n++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom));
      step();
    end
    check("sat_reach", 32'(commit_count_o), 32'hFFFF);
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 3'($urandom_range(1, 7)),
            3'($urandom), 3'($urandom));
      step();
    end
    check("sat_hold", 32'(commit_count_o), 32'hFFFF);
    regwrite_i = 1'b0;
    repeat (3) step();
    check("sat_idle", 32'(commit_count_o), 32'hFFFF);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
